// File: rtl/fault_capture_pkg.sv
// fault_capture_pkg: shared state encoding and widths for the fault capture sequencer.
package fault_capture_pkg;

    localparam int CNT_W_DEF    = 32;
    localparam int N_FAULT_DEF  = 8;
    localparam int SW_FAULT_BIT = N_FAULT_DEF;
    localparam int FF_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_FROZEN  = 3'd4
    } state_e;

endpackage

// File: rtl/fault_edge_prio.sv
// fault_edge_prio: masked rising-edge detect of fault levels, software trigger merge
// and lowest-index priority encode of the resulting event vector.
module fault_edge_prio
    import fault_capture_pkg::*;
#(
    parameter int N_FAULT = N_FAULT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               usr_rst,
    input  logic [N_FAULT-1:0] fault_i,
    input  logic [N_FAULT-1:0] mask_i,
    input  logic               sw_trig_i,
    output logic [N_FAULT:0]   events_o,
    output logic               any_o,
    output logic [FF_W-1:0]    first_o
);

    logic [N_FAULT-1:0] prev_q;
    logic [N_FAULT-1:0] prev_d;
    logic [N_FAULT-1:0] edge_v;

    // prev tracks the raw level in every state so a level held across arming never fires
    assign prev_d = usr_rst ? '0 : fault_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= '0;
        else       prev_q <= prev_d;
    end

    assign edge_v   = fault_i & mask_i & ~prev_q;
    assign events_o = {sw_trig_i, edge_v};
    assign any_o    = |events_o;

    always_comb begin
        first_o = FF_W'(N_FAULT);
        for (int i = N_FAULT - 1; i >= 0; i--)
            if (edge_v[i]) first_o = FF_W'(i);
    end

endmodule

// File: rtl/fault_capture_ctrl.sv
// fault_capture_ctrl: arms post-mortem capture, waits for a qualified fault, counts
// post-fault ticks, freezes the NPI buffer and holds it until software acknowledges.
module fault_capture_ctrl
    import fault_capture_pkg::*;
#(
    parameter int N_FAULT = N_FAULT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               usr_rst,
    input  logic               arm,
    input  logic               sample_tick,
    input  logic [N_FAULT-1:0] fault_in,
    input  logic [N_FAULT-1:0] fault_mask,
    input  logic               sw_trig,
    input  logic [CNT_W-1:0]   cfg_pre_cnt,
    input  logic [CNT_W-1:0]   cfg_post_cnt,
    input  logic               cfg_auto_rearm,
    input  logic               rd_ack,
    output logic               npi_enable,
    output logic [CNT_W-1:0]   post_count,
    output logic [N_FAULT:0]   fault_latch,
    output logic [FF_W-1:0]    first_fault,
    output logic [CNT_W-1:0]   fault_ts,
    output logic [2:0]         state,
    output logic               done,
    output logic               irq
);

    state_e             state_q, state_d;
    logic               npi_q, npi_d;
    logic               done_q, done_d;
    logic               irq_q, irq_d;
    logic [CNT_W-1:0]   samp_q, samp_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic [CNT_W-1:0]   pre_sh_q, pre_sh_d;
    logic [CNT_W-1:0]   post_sh_q, post_sh_d;
    logic [CNT_W-1:0]   ts_q, ts_d;
    logic [N_FAULT:0]   latch_q, latch_d;
    logic [FF_W-1:0]    first_q, first_d;
    logic [N_FAULT:0]   events;
    logic               ev_any;
    logic [FF_W-1:0]    ev_first;
    logic               restart;
    logic               counting;

    fault_edge_prio #(
        .N_FAULT (N_FAULT)
    ) u_edge (
        .clk       (clk),
        .reset     (reset),
        .usr_rst   (usr_rst),
        .fault_i   (fault_in),
        .mask_i    (fault_mask),
        .sw_trig_i (sw_trig),
        .events_o  (events),
        .any_o     (ev_any),
        .first_o   (ev_first)
    );

    assign counting = state_q inside {ST_PREFILL, ST_ARMED, ST_POST};

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        irq_d     = irq_q;
        samp_d    = samp_q;
        post_d    = post_q;
        pre_sh_d  = pre_sh_q;
        post_sh_d = post_sh_q;
        ts_d      = ts_q;
        latch_d   = latch_q;
        first_d   = first_q;
        restart   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_PREFILL;
                    restart = 1'b1;
                end
            end
            ST_PREFILL: begin
                if (samp_q >= pre_sh_q) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (ev_any) begin
                    state_d = ST_POST;
                    latch_d = events;
                    first_d = ev_first;
                    ts_d    = samp_q;
                    post_d  = '0;
                end
            end
            ST_POST: begin
                latch_d = latch_q | events;
                if (post_q >= post_sh_q) begin
                    state_d = ST_FROZEN;
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                end else if (sample_tick) begin
                    post_d = post_q + 1'b1;
                end
            end
            ST_FROZEN: begin
                if (rd_ack) begin
                    irq_d   = 1'b0;
                    state_d = cfg_auto_rearm ? ST_PREFILL : ST_IDLE;
                    restart = cfg_auto_rearm;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (counting && sample_tick && !(&samp_q)) samp_d = samp_q + 1'b1;
        // Config is sampled only when a run starts; later writes wait for the next run.
        if (restart) begin
            pre_sh_d  = cfg_pre_cnt;
            post_sh_d = cfg_post_cnt;
            samp_d    = '0;
            latch_d   = '0;
            post_d    = '0;
        end
        npi_d = state_d inside {ST_PREFILL, ST_ARMED, ST_POST};
        if (usr_rst) begin
            state_d   = ST_IDLE;
            npi_d     = 1'b0;
            done_d    = 1'b0;
            irq_d     = 1'b0;
            samp_d    = '0;
            post_d    = '0;
            pre_sh_d  = '0;
            post_sh_d = '0;
            ts_d      = '0;
            latch_d   = '0;
            first_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            npi_q     <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            samp_q    <= '0;
            post_q    <= '0;
            pre_sh_q  <= '0;
            post_sh_q <= '0;
            ts_q      <= '0;
            latch_q   <= '0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            npi_q     <= npi_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
            samp_q    <= samp_d;
            post_q    <= post_d;
            pre_sh_q  <= pre_sh_d;
            post_sh_q <= post_sh_d;
            ts_q      <= ts_d;
            latch_q   <= latch_d;
            first_q   <= first_d;
        end
    end

    assign npi_enable  = npi_q;
    assign post_count  = post_q;
    assign fault_latch = latch_q;
    assign first_fault = first_q;
    assign fault_ts    = ts_q;
    assign state       = state_q;
    assign done        = done_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_fault_capture_ctrl.sv
// tb_fault_capture_ctrl: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of the capture sequencer.
module tb_fault_capture_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          usr_rst = 1'b0;
    logic          arm = 1'b0;
    logic          sample_tick = 1'b0;
    logic [N-1:0]  fault_in = '0;
    logic [N-1:0]  fault_mask = '1;
    logic          sw_trig = 1'b0;
    logic [31:0]   cfg_pre_cnt = '0;
    logic [31:0]   cfg_post_cnt = '0;
    logic          cfg_auto_rearm = 1'b0;
    logic          rd_ack = 1'b0;
    logic          npi_enable;
    logic [31:0]   post_count;
    logic [N:0]    fault_latch;
    logic [3:0]    first_fault;
    logic [31:0]   fault_ts;
    logic [2:0]    state;
    logic          done;
    logic          irq;

    always #5 clk = ~clk;

    fault_capture_ctrl #(.N_FAULT(N), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .usr_rst        (usr_rst),
        .arm            (arm),
        .sample_tick    (sample_tick),
        .fault_in       (fault_in),
        .fault_mask     (fault_mask),
        .sw_trig        (sw_trig),
        .cfg_pre_cnt    (cfg_pre_cnt),
        .cfg_post_cnt   (cfg_post_cnt),
        .cfg_auto_rearm (cfg_auto_rearm),
        .rd_ack         (rd_ack),
        .npi_enable     (npi_enable),
        .post_count     (post_count),
        .fault_latch    (fault_latch),
        .first_fault    (first_fault),
        .fault_ts       (fault_ts),
        .state          (state),
        .done           (done),
        .irq            (irq)
    );

    // Behavioural model: states as plain integers 0..4
    int           m_st = 0;
    bit           m_npi = 0, m_done = 0, m_irq = 0;
    logic [31:0]  m_samp = '0, m_post = '0, m_pre = '0, m_psh = '0, m_ts = '0;
    logic [N:0]   m_latch = '0;
    int           m_first = 0;
    logic [N-1:0] m_prev = '0;

    function automatic int lowest(input logic [N:0] v);
        for (int i = 0; i <= N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic m_clear();
        m_st = 0; m_npi = 0; m_done = 0; m_irq = 0;
        m_samp = '0; m_post = '0; m_pre = '0; m_psh = '0; m_ts = '0;
        m_latch = '0; m_first = 0; m_prev = '0;
    endtask

    task automatic m_start();
        m_samp = '0; m_latch = '0; m_post = '0;
        m_pre = cfg_pre_cnt; m_psh = cfg_post_cnt;
    endtask

    always @(posedge clk or posedge reset) begin : model
        logic [N:0] ev;
        bit act;
        if (reset || usr_rst) m_clear();
        else begin
            ev = {sw_trig, fault_in & fault_mask & ~m_prev};
            m_prev = fault_in;
            act = (m_st >= 1 && m_st <= 3);
            m_done = 0;
            if (m_st == 0) begin
                if (arm) begin m_st = 1; m_start(); end
            end else if (m_st == 1) begin
                if (m_samp >= m_pre) m_st = 2;
            end else if (m_st == 2) begin
                if (ev != 0) begin
                    m_st = 3; m_latch = ev; m_first = lowest(ev); m_ts = m_samp; m_post = '0;
                end
            end else if (m_st == 3) begin
                m_latch = m_latch | ev;
                if (m_post >= m_psh) begin m_st = 4; m_done = 1; m_irq = 1; end
                else if (sample_tick) m_post = m_post + 1;
            end else if (rd_ack) begin
                m_irq = 0;
                if (cfg_auto_rearm) begin m_st = 1; m_start(); end
                else m_st = 0;
            end
            if (act && sample_tick && m_samp != 32'hFFFF_FFFF) m_samp = m_samp + 1;
            m_npi = (m_st >= 1 && m_st <= 3);
        end
    end

    int n_pass = 0, n_tot = 0, n_done = 0, tcnt = 0;
    bit trand = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic compare_all();
        chk("state", 64'(state), 64'(m_st));
        chk("npi_enable", 64'(npi_enable), 64'(m_npi));
        chk("post_count", 64'(post_count), 64'(m_post));
        chk("fault_latch", 64'(fault_latch), 64'(m_latch));
        chk("first_fault", 64'(first_fault), 64'(m_first));
        chk("fault_ts", 64'(fault_ts), 64'(m_ts));
        chk("done", 64'(done), 64'(m_done));
        chk("irq", 64'(irq), 64'(m_irq));
        if (done) n_done++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_all();
            @(posedge clk);
            #2;
            tcnt++;
            sample_tick = trand ? 1'($urandom_range(0, 1)) : (tcnt % 3 == 0);
        end
    endtask

    task automatic wait_st(input int s, input int budget);
        int n = 0;
        while (m_st != s && n < budget) begin cyc(1); n++; end
        if (m_st != s) begin
            n_tot++;
            $display("FAIL wait_state: got state %0d expected %0d (timeout)", m_st, s);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1; cyc(1); arm = 1'b0;
    endtask

    task automatic pulse_ack(input bit rearm);
        cfg_auto_rearm = rearm; rd_ack = 1'b1; cyc(1); rd_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int n;
        cyc(2);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_npi", 64'(npi_enable), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_latch", 64'(fault_latch), 64'd0);
        reset = 1'b0;
        cyc(1);

        // Single fault on bit 5
        cfg_pre_cnt = 4; cfg_post_cnt = 10; fault_mask = '1;
        pulse_arm();
        chk("arm_prefill", 64'(state), 64'd1);
        chk("arm_npi", 64'(npi_enable), 64'd1);
        wait_st(2, 60);
        d0 = n_done;
        fault_in[5] = 1'b1;
        cyc(1);
        chk("trig_post", 64'(state), 64'd3);
        wait_st(4, 100);
        chk("s1_state", 64'(state), 64'd4);
        chk("s1_first", 64'(first_fault), 64'd5);
        chk("s1_latch", 64'(fault_latch), 64'h020);
        chk("s1_post", 64'(post_count), 64'd10);
        chk("s1_npi", 64'(npi_enable), 64'd0);
        chk("s1_irq", 64'(irq), 64'd1);
        cyc(3);
        chk("s1_done_once", 64'(n_done - d0), 64'd1);
        pulse_ack(1'b0);
        chk("ack_idle", 64'(state), 64'd0);
        chk("ack_irq", 64'(irq), 64'd0);

        // Simultaneous bits 2 and 6, then bit 1 during POST
        fault_in = '0; cyc(2);
        pulse_arm();
        wait_st(2, 60);
        fault_in[2] = 1'b1; fault_in[6] = 1'b1;
        cyc(1);
        chk("s2_first_early", 64'(first_fault), 64'd2);
        cyc(2);
        fault_in[1] = 1'b1;
        wait_st(4, 100);
        chk("s2_first", 64'(first_fault), 64'd2);
        chk("s2_latch", 64'(fault_latch), 64'h046);

        // Auto re-arm with bit 3 already high
        cfg_pre_cnt = 4; cfg_post_cnt = 3; fault_in[3] = 1'b1;
        cyc(2);
        pulse_ack(1'b1);
        chk("rearm_state", 64'(state), 64'd1);
        chk("rearm_npi", 64'(npi_enable), 64'd1);
        chk("rearm_irq", 64'(irq), 64'd0);
        wait_st(2, 60);
        cyc(5);
        chk("held_no_trig", 64'(state), 64'd2);
        fault_mask[3] = 1'b0; fault_in[3] = 1'b0; cyc(1);
        fault_in[3] = 1'b1; cyc(3);
        chk("masked_no_trig", 64'(state), 64'd2);
        sw_trig = 1'b1; cyc(1); sw_trig = 1'b0;
        chk("sw_state", 64'(state), 64'd3);
        chk("sw_first", 64'(first_fault), 64'd8);
        chk("sw_latch", 64'(fault_latch), 64'h100);
        cfg_post_cnt = 50;
        wait_st(4, 60);
        chk("shadow_post", 64'(post_count), 64'd3);
        pulse_ack(1'b0);

        // pre=0, post=0 timing
        fault_mask = '1; fault_in = '0; cfg_pre_cnt = 0; cfg_post_cnt = 0;
        cyc(2);
        pulse_arm();
        chk("p0_prefill", 64'(state), 64'd1);
        cyc(1);
        chk("p0_armed", 64'(state), 64'd2);
        fault_in[0] = 1'b1; cyc(1);
        chk("p0_post", 64'(state), 64'd3);
        cyc(1);
        chk("p0_frozen", 64'(state), 64'd4);
        chk("p0_post_cnt", 64'(post_count), 64'd0);
        chk("p0_done", 64'(done), 64'd1);
        pulse_ack(1'b0);

        // usr_rst at post_count 7
        fault_in = '0; cfg_pre_cnt = 2; cfg_post_cnt = 10;
        cyc(2);
        pulse_arm();
        wait_st(2, 60);
        fault_in[4] = 1'b1; cyc(1);
        n = 0;
        while (m_post != 7 && n < 100) begin cyc(1); n++; end
        chk("post_reach7", 64'(post_count), 64'd7);
        usr_rst = 1'b1; cyc(1); usr_rst = 1'b0;
        chk("ur_state", 64'(state), 64'd0);
        chk("ur_post", 64'(post_count), 64'd0);
        chk("ur_latch", 64'(fault_latch), 64'd0);
        chk("ur_ts", 64'(fault_ts), 64'd0);
        chk("ur_first", 64'(first_fault), 64'd0);
        fault_in = '0; cyc(2);
        pulse_arm();
        wait_st(2, 60);
        fault_in[7] = 1'b1; cyc(1);
        wait_st(4, 100);
        chk("ur_clean_first", 64'(first_fault), 64'd7);
        chk("ur_clean_latch", 64'(fault_latch), 64'h080);
        chk("ur_clean_post", 64'(post_count), 64'd10);
        pulse_ack(1'b0);

        // Async reset mid-PREFILL
        fault_in = '0; cfg_pre_cnt = 20;
        pulse_arm();
        cyc(5);
        reset = 1'b1; #1;
        chk("ar_state", 64'(state), 64'd0);
        chk("ar_npi", 64'(npi_enable), 64'd0);
        chk("ar_latch", 64'(fault_latch), 64'd0);
        cyc(1); reset = 1'b0; cyc(1);
        cfg_pre_cnt = 3; cfg_post_cnt = 2;
        pulse_arm();
        wait_st(2, 60);
        fault_in[1] = 1'b1; cyc(1);
        wait_st(4, 60);
        chk("ar_clean_first", 64'(first_fault), 64'd1);
        chk("ar_clean_post", 64'(post_count), 64'd2);
        pulse_ack(1'b0);

        // Random traffic against the model
        trand = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            fault_in = fault_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
            arm = ($urandom_range(0, 15) == 0);
            rd_ack = ($urandom_range(0, 9) == 0);
            sw_trig = ($urandom_range(0, 40) == 0);
            usr_rst = ($urandom_range(0, 400) == 0);
            if ($urandom_range(0, 50) == 0) fault_mask = N'($urandom);
            cfg_pre_cnt = $urandom_range(0, 6);
            cfg_post_cnt = $urandom_range(0, 6);
            cfg_auto_rearm = 1'($urandom_range(0, 1));
            cyc(1);
        end
        arm = 1'b0; rd_ack = 1'b0; sw_trig = 1'b0; usr_rst = 1'b0;
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
